// File: rtl/wavepredictor_axil_regs.sv
// AXI4-Lite slave register file for the wave predictor control port.
// Four 32-bit R/W registers with byte strobes, OKAY-only responses,
// and a one-cycle sample_valid strobe on every committed write to reg1.
module wavepredictor_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_ctrl,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_sample,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_coef,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_scratch,
  output logic                              sample_valid
);

  localparam int unsigned DW        = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NUM_BYTES = DW / 8;
  localparam int unsigned NUM_REGS  = 4;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e        wstate_q, wstate_d;
  rstate_e        rstate_q, rstate_d;
  logic           awready_q, awready_d;
  logic           bvalid_q, bvalid_d;
  logic           sample_valid_q, sample_valid_d;
  logic           arready_q, arready_d;
  logic           rvalid_q, rvalid_d;
  logic [1:0]     araddr_q, araddr_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [DW-1:0]  regs_q [NUM_REGS];
  logic [DW-1:0]  regs_d [NUM_REGS];

  logic           w_hs;
  logic           r_hs;
  logic [1:0]     widx;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign widx = S_AXI_AWADDR[3:2];
  assign w_hs = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign r_hs = arready_q & S_AXI_ARVALID;

  // Write channel state and register storage.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q       <= W_IDLE;
      awready_q      <= 1'b0;
      bvalid_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q       <= wstate_d;
      awready_q      <= awready_d;
      bvalid_q       <= bvalid_d;
      sample_valid_q <= sample_valid_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Write FSM next state: accept one AW+W pair, then wait for BREADY.
  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE: if (w_hs) wstate_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: ready pulse, strobed commit, response and sample strobe.
  always_comb begin
    awready_d      = 1'b0;
    bvalid_d       = bvalid_q;
    sample_valid_d = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    unique case (wstate_q)
      W_IDLE: begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q;
        if (w_hs) begin
          for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (S_AXI_WSTRB[b]) regs_d[widx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
          end
          bvalid_d       = 1'b1;
          sample_valid_d = (widx == 2'd1);
        end
      end
      W_RESP: if (S_AXI_BREADY) bvalid_d = 1'b0;
      default: bvalid_d = 1'b0;
    endcase
  end

  // Read channel state and captured response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      araddr_q  <= 2'd0;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read FSM next state: accept one AR, then hold data until RREADY.
  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE: if (r_hs) rstate_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read FSM outputs: ready pulse, address latch, pre-edge register capture.
  always_comb begin
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    unique case (rstate_q)
      R_IDLE: begin
        arready_d = S_AXI_ARVALID & ~arready_q;
        if (S_AXI_ARVALID && !arready_q) araddr_d = S_AXI_ARADDR[3:2];
        if (r_hs) begin
          rdata_d  = regs_q[araddr_q];
          rvalid_d = 1'b1;
        end
      end
      R_DATA: if (S_AXI_RREADY) rvalid_d = 1'b0;
      default: rvalid_d = 1'b0;
    endcase
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign reg0_ctrl     = regs_q[0];
  assign reg1_sample   = regs_q[1];
  assign reg2_coef     = regs_q[2];
  assign reg3_scratch  = regs_q[3];
  assign sample_valid  = sample_valid_q;

endmodule

// File: tb/tb_wavepredictor_axil_regs.sv
// Scoreboard bench for the wave predictor AXI4-Lite register file.
module tb_wavepredictor_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [31:0] reg0_ctrl, reg1_sample, reg2_coef, reg3_scratch;
  logic        sample_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] rq[$];
  logic [1:0]  bq[$];
  int sv_pulses = 0;
  int sv_high = 0;
  logic sv_prev = 1'b0;

  wavepredictor_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg0_ctrl(reg0_ctrl), .reg1_sample(reg1_sample),
    .reg2_coef(reg2_coef), .reg3_scratch(reg3_scratch),
    .sample_valid(sample_valid)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: pop and compare on every B and R handshake.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) timeout("b_unexpected");
        else chk("bresp", 32'(S_AXI_BRESP), 32'(bq.pop_front()));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) timeout("r_unexpected");
        else begin
          chk("rdata", S_AXI_RDATA, rq.pop_front());
          chk("rresp", 32'(S_AXI_RRESP), 32'd0);
        end
      end
    end
  end

  // Count sample_valid pulses and high cycles.
  always @(negedge ACLK) begin
    if (sample_valid === 1'b1) sv_high++;
    if (sample_valid === 1'b1 && sv_prev !== 1'b1) sv_pulses++;
    sv_prev = sample_valid;
  end

  task automatic wait_neg_awready();
    int t = 0;
    while (1) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY === 1'b1) break;
      t++;
      if (t > 30) begin timeout("awready"); break; end
    end
  endtask

  task automatic wait_neg_arready();
    int t = 0;
    while (1) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY === 1'b1) break;
      t++;
      if (t > 30) begin timeout("arready"); break; end
    end
  endtask

  task automatic wait_pos_bidle();
    int t = 0;
    while (1) begin
      @(posedge ACLK); #1;
      if (S_AXI_BVALID === 1'b0) break;
      t++;
      if (t > 30) begin timeout("bvalid_drop"); break; end
    end
  endtask

  task automatic wait_pos_ridle();
    int t = 0;
    while (1) begin
      @(posedge ACLK); #1;
      if (S_AXI_RVALID === 1'b0) break;
      t++;
      if (t > 30) begin timeout("rvalid_drop"); break; end
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lead);
    bq.push_back(2'b00);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge ACLK);
      chk("aw_alone_ready", 32'(S_AXI_AWREADY), 32'd0);
    end
    if (aw_lead > 0) begin @(posedge ACLK); #1; end
    S_AXI_WVALID = 1'b1;
    wait_neg_awready();
    chk("wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("bvalid_rise", 32'(S_AXI_BVALID), 32'd1);
    chk("sample_valid_at_b", 32'(sample_valid), (addr[3:2] == 2'd1) ? 32'd1 : 32'd0);
    wait_pos_bidle();
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    rq.push_back(exp);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    wait_neg_arready();
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_rise", 32'(S_AXI_RVALID), 32'd1);
    wait_pos_ridle();
  endtask

  initial begin
    int p0, h0;
    logic [31:0] vals [4];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3; vals[3] = 32'h4;

    // Reset and check idle values.
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_reg0", reg0_ctrl, 32'd0);
    chk("rst_reg3", reg3_scratch, 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'h0);

    // Write all four registers, one sample_valid pulse expected.
    p0 = sv_pulses; h0 = sv_high;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), vals[i], 4'hF, 0);
    chk("sv_pulse_count", 32'(sv_pulses - p0), 32'd1);
    chk("sv_pulse_width", 32'(sv_high - h0), 32'd1);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), vals[i]);

    // Byte strobes merge into existing contents.
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(4'h8, 32'h1234_5678, 4'b0101, 0);
    axi_read(4'h8, 32'hFF34_FF78);
    chk("reg2_coef", reg2_coef, 32'hFF34_FF78);

    // AW ahead of W by three cycles; ignored low address bits.
    axi_write(4'h3, 32'h0000_00AA, 4'hF, 3);
    chk("reg0_after_lead", reg0_ctrl, 32'h0000_00AA);
    axi_read(4'h2, 32'h0000_00AA);

    // Zero strobe: no change to reg1, but still a sample pulse.
    axi_write(4'h4, 32'hFFFF_FFFF, 4'h0, 0);
    axi_read(4'h4, 32'h2);

    // B backpressure with a second AW/W waiting.
    bq.push_back(2'b00);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    wait_neg_awready();
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      chk("aw_blocked", 32'(S_AXI_AWREADY), 32'd0);
      chk("reg0_hold", reg0_ctrl, 32'h55);
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    wait_pos_bidle();
    chk("reg0_one_commit", reg0_ctrl, 32'h55);

    // R backpressure: data stays stable.
    @(posedge ACLK); #1;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    wait_neg_arready();
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
      chk("rdata_hold", S_AXI_RDATA, 32'h55);
    end
    rq.push_back(32'h55);
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b1;
    wait_pos_ridle();

    // Same-edge write and read of reg3: read sees the old value.
    bq.push_back(2'b00);
    rq.push_back(32'h4);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'hA5A5_A5A5; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'hC; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    wait_neg_awready();
    chk("collide_arready", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    wait_pos_bidle();
    wait_pos_ridle();
    axi_read(4'hC, 32'hA5A5_A5A5);

    // Reset while BVALID is pending.
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    wait_neg_awready();
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("pre_reset_bvalid", 32'(S_AXI_BVALID), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("reset_drops_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("reset_reg1", reg1_sample, 32'd0);
    chk("reset_reg3", reg3_scratch, 32'd0);
    ARESET = 1'b0; S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'h0);

    repeat (3) @(posedge ACLK);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
